uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit-side buffer that sits directly upstream of `uart_fd`. It accepts bytes from a host write port into a DEPTH-entry FIFO and drains them one at a time into `uart_fd`'s `tx_start`/`tx_data`/`tx_busy` handshake. The host can therefore queue a burst without polling `tx_busy`. Overflow is reported through a sticky flag.

## Interface

- `DEPTH`, 16: FIFO entries; power of two, ≥ 2.
- `clk` in 1: sole clock, shared with `uart_fd`.
- `rst_` in 1: asynchronous, active-low reset.
- `wr_en` in 1: host write strobe, one byte per cycle.
- `wr_data` in 8: byte to enqueue.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `count` out $clog2(DEPTH)+1: bytes stored, excluding the byte currently held in `tx_data`.
- `overflow` out 1: sticky; set when a write is dropped.
- `clr_overflow` in 1: clears `overflow`.
- `tx_busy` in 1: from `uart_fd`.
- `tx_start` out 1: to `uart_fd`; registered.
- `tx_data` out 8: to `uart_fd`; registered and stable for the whole frame.
- `idle` out 1: high when `empty` is high and the FSM is in IDLE.

## Operation

- Storage: circular buffer with `rd_ptr`/`wr_ptr` of $clog2(DEPTH) bits, wrapping DEPTH-1 → 0, plus a separate `count` register. `full`/`empty` are decoded from registered `count`.
- Write: an accepted write (`wr_en` high and `full` low) stores `wr_data` at `wr_ptr`, advances `wr_ptr` and increments `count`.
- Write while full: the write is dropped and `overflow` is set. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- `overflow`: `clr_overflow` clears it. If `clr_overflow` and a dropped write occur in the same cycle, set wins.
- FSM states: IDLE, START, WAIT_DONE.
  - IDLE → START when `empty` is low and `tx_busy` is low. On this edge: `tx_data` ← `mem[rd_ptr]`, `rd_ptr`++, `count`--.
  - START: `tx_start` = 1. Stay in START while `tx_busy` is low. Move to WAIT_DONE on the first cycle `tx_busy` is sampled high; `tx_start` drops on that same edge.
  - WAIT_DONE: `tx_start` = 0. Move to IDLE when `tx_busy` is sampled low.
- `tx_data` changes only on the IDLE → START edge.
- `tx_start` is the registered form of "next state == START".
- Ordering: strictly first-in, first-out; no byte is duplicated or skipped.

## Timing

- Reset values: `tx_start`=0, `tx_data`=8'h00, `count`=0, `empty`=1, `full`=0, `overflow`=0, `idle`=1, pointers=0, state=IDLE.
- Reset mid-frame: all queued bytes are discarded immediately. `uart_fd` is reset by the same `rst_`.
- Latency from write into an empty, idle block:
  - `wr_en` is sampled at edge N.
  - `count`=1 after edge N.
  - `tx_start` rises after edge N+1; `count` returns to 0 at that same edge.
- Frame-to-frame gap: after `tx_busy` falls (sampled at edge M), the FSM is in IDLE after M, so `tx_start` rises again after M+1. There are 2 clocks of `tx_busy` low between frames.
- `tx_start` width equals the number of cycles until `uart_fd` raises `tx_busy`. Nominally 1–2 cycles; unbounded if `tx_busy` never rises.
- `full`, `empty` and `count` reflect the state after the previous edge. A write and a pop in the same cycle are both visible one cycle later.
- Capacity: DEPTH bytes are queued plus one byte in flight in `tx_data`.

## Test plan

- Single byte: write 8'hA5 with the UART idle → `tx_start` high 2 edges later, `tx_data`=8'hA5, `count` back to 0; `idle` returns to 1 after `tx_busy` falls.
- Burst and order: write 8'h00..8'h0F back-to-back (DEPTH=16) with loopback into `uart_fd` RX → `rx_data` sequence is 00..0F; no `rx_error`.
- Overflow: hold `tx_busy` high, write 17 bytes 8'h10..8'h20 → `full`=1 after 16 writes; the 17th write is dropped and `overflow`=1. After `tx_busy` falls, 8'h10..8'h1F are transmitted and 8'h20 never appears. `clr_overflow` clears the flag.
- Push/pop same cycle: with `count`=3, drive `wr_en` on the IDLE → START edge → `count` stays 3 and the new byte is transmitted last.
- Reset mid-frame: queue 5 bytes, pulse `rst_` low while `tx_busy`=1 → outputs immediately return to reset values; no further `tx_start` until a new write.
- Pointer wrap: perform 40 single writes interleaved with drains (DEPTH=16) → every byte is transmitted in order across the 15 → 0 pointer wraps.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO draining into a UART tx_start/tx_data/tx_busy handshake; tx_start rises two edges after a write into an empty, idle block.
// Writes while full are dropped and set the sticky overflow flag; tx_busy stalls the drain side.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_overflow,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   idle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign idle  = empty && (state == IDLE);
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty && !tx_busy;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && full)     overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  // tx_data is only loaded when a byte is popped, so it holds for the whole frame.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state    <= START;
            tx_start <= 1'b1;
            tx_data  <= mem[rd_ptr];
          end
        end
        START: begin
          if (tx_busy) begin
            state    <= WAIT_DONE;
            tx_start <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          tx_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: behavioural UART busy responder, scoreboard of expected transmitted bytes, directed checks.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int FRAME = 4;

  logic                   clk;
  logic                   rst_;
  logic                   wr_en;
  logic [7:0]             wr_data;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   clr_overflow;
  logic                   tx_busy;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic                   idle;

  int         n_cmp = 0;
  int         n_err = 0;
  int         starts_seen = 0;
  logic       hold_busy = 1'b0;
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_(rst_), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .clr_overflow(clr_overflow), .tx_busy(tx_busy), .tx_start(tx_start),
    .tx_data(tx_data), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // UART stand-in: raises tx_busy the cycle after tx_start, holds it FRAME cycles.
  initial begin
    int frame_left;
    frame_left = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_) begin
        tx_busy = 1'b0;
        frame_left = 0;
      end else if (hold_busy) begin
        tx_busy = 1'b1;
      end else if (frame_left > 0) begin
        frame_left--;
        tx_busy = (frame_left != 0);
      end else if (tx_start && !tx_busy) begin
        tx_busy = 1'b1;
        frame_left = FRAME;
      end else begin
        tx_busy = 1'b0;
      end
    end
  end

  // Monitor: each new frame must carry the oldest expected byte; tx_data stable while in flight.
  initial begin
    logic       prev_start;
    logic [7:0] last_data;
    logic [7:0] exp_v;
    prev_start = 1'b0;
    last_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rst_) begin
        if (tx_start && !prev_start) begin
          starts_seen++;
          last_data = tx_data;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_frame: got tx_data 0x%0h, want no frame", tx_data);
          end else begin
            exp_v = exp_q.pop_front();
            chk("tx_data_order", int'(tx_data), int'(exp_v));
          end
        end else if (tx_start || tx_busy) begin
          chk("tx_data_stable", int'(tx_data), int'(last_data));
        end
      end
      prev_start = rst_ && tx_start;
    end
  end

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (!(idle && !tx_busy && exp_q.size() == 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, int'(n < 2000), 1);
  endtask

  initial begin
    int n;
    int starts_before;
    rst_ = 1'b0;
    wr_en = 1'b0;
    wr_data = 8'h00;
    clr_overflow = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_idle", int'(idle), 1);
    rst_ = 1'b1;
    @(negedge clk);

    // Single byte latency
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    chk("single_count_after_N", int'(count), 1);
    chk("single_start_after_N", int'(tx_start), 0);
    chk("single_idle_after_N", int'(idle), 0);
    @(negedge clk);
    chk("single_start_after_N1", int'(tx_start), 1);
    chk("single_count_after_N1", int'(count), 0);
    chk("single_data", int'(tx_data), 8'hA5);
    chk("single_idle_busy", int'(idle), 0);
    wait_drain("single");
    chk("single_idle_end", int'(idle), 1);

    // Back-to-back burst
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      wr(8'(i));
    end
    chk("burst_no_overflow", int'(overflow), 0);
    wait_drain("burst");

    // Overflow with the UART held busy
    hold_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i));
    chk("ovf_full_16", int'(full), 1);
    chk("ovf_count_16", int'(count), 16);
    chk("ovf_flag_before", int'(overflow), 0);
    wr(8'h20);
    chk("ovf_flag_set", int'(overflow), 1);
    chk("ovf_count_held", int'(count), 16);
    wr_en = 1'b1;
    wr_data = 8'h20;
    clr_overflow = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    chk("ovf_set_wins", int'(overflow), 1);
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'h10 + i));
    hold_busy = 1'b0;
    wait_drain("overflow");
    chk("ovf_stays_clear", int'(overflow), 0);

    // Push and pop on the same edge with count == 3
    hold_busy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'(8'hC1 + i));
      wr(8'(8'hC1 + i));
    end
    chk("pp_count_3", int'(count), 3);
    hold_busy = 1'b0;
    @(negedge clk);
    exp_q.push_back(8'hC4);
    wr_en = 1'b1;
    wr_data = 8'hC4;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pp_count_stays_3", int'(count), 3);
    chk("pp_started", int'(tx_start), 1);
    wait_drain("pushpop");

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'(8'hE0 + i));
      wr(8'(8'hE0 + i));
    end
    n = 0;
    while (!tx_busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_busy_seen", int'(n < 100), 1);
    rst_ = 1'b0;
    #1;
    exp_q.delete();
    chk("rstmid_tx_start", int'(tx_start), 0);
    chk("rstmid_tx_data", int'(tx_data), 0);
    chk("rstmid_count", int'(count), 0);
    chk("rstmid_empty", int'(empty), 1);
    chk("rstmid_idle", int'(idle), 1);
    starts_before = starts_seen;
    @(negedge clk);
    rst_ = 1'b1;
    repeat (30) @(negedge clk);
    chk("rstmid_no_new_frame", starts_seen, starts_before);

    // Pointer wrap: 40 single writes each drained
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'(8'h40 + i));
      wr(8'(8'h40 + i));
      wait_drain("wrap");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
